// File: rtl/spike_packet_injector.sv
// Spike event FIFO feeding a two-phase bundled-data request/ack port (switch L1 input).
// Optional macro INJ_DROP_ZERO_MASK_EN: zero-mask packets are discarded and counted on drop_count.
module spike_packet_injector #(
  parameter int MSG_W     = 10,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = MSG_W + ADDR_W,
  parameter int DEPTH     = 8,
  parameter int SETUP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MSG_W-1:0]  in_msg,
  input  logic [ADDR_W-1:0] in_mask,
  output logic              ReqOut,
  output logic [DATA_W-1:0] DataOut,
  input  logic              AckOut,
  output logic              busy,
`ifdef INJ_DROP_ZERO_MASK_EN
  output logic [7:0]        drop_count,
`endif
  output logic [15:0]       sent_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int CNT_W = $clog2(SETUP_CYC + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [DATA_W-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_nxt_s;
  logic [PTR_W-1:0]   rd_ptr_nxt_s;
  logic [PTR_W-1:0]   count_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic               in_ready_r;
  logic               busy_r;
  logic               req_r;
  logic [DATA_W-1:0]  data_r;
  logic               ack_meta_r;
  logic               ack_sync_r;
  logic [15:0]        sent_r;
  logic               push_s;
  logic               pop_s;
  logic               load_s;
  logic               toggle_s;
  logic               sent_inc_s;
  logic               empty_s;
  logic               zero_mask_s;
  logic [DATA_W-1:0]  head_s;

  // FIFO status, head entry and next pointer values
  always_comb begin
    push_s  = in_valid && in_ready_r;
    empty_s = (wr_ptr_r == rd_ptr_r);
    head_s  = mem_r[rd_ptr_r[AW-1:0]];
`ifdef INJ_DROP_ZERO_MASK_EN
    zero_mask_s = (head_s[ADDR_W-1:0] == {ADDR_W{1'b0}});
`else
    zero_mask_s = 1'b0;
`endif
    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1'b1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1'b1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    count_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
  end

  // Handshake FSM: next state and per-cycle control strobes
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    pop_s       = 1'b0;
    load_s      = 1'b0;
    toggle_s    = 1'b0;
    sent_inc_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s = 1'b1;
          if (zero_mask_s) begin
            state_nxt_s = IDLE;
          end else begin
            load_s      = 1'b1;
            cnt_nxt_s   = {CNT_W{1'b0}};
            state_nxt_s = SETUP;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETUP: begin
        cnt_nxt_s = cnt_r + CNT_W'(1'b1);
        if (cnt_nxt_s == CNT_W'(SETUP_CYC)) begin
          toggle_s    = 1'b1;
          state_nxt_s = WAIT_ACK;
        end else begin
          state_nxt_s = SETUP;
        end
      end
      WAIT_ACK: begin
        if (ack_sync_r == req_r) begin
          sent_inc_s = 1'b1;
          if (!empty_s && !zero_mask_s) begin
            pop_s       = 1'b1;
            load_s      = 1'b1;
            cnt_nxt_s   = {CNT_W{1'b0}};
            state_nxt_s = SETUP;
          end else if (!empty_s) begin
            // zero-mask head after a completion is discarded on the way back to IDLE
            pop_s       = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = WAIT_ACK;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {in_msg, in_mask};
    end
  end

  // Control state, ack synchroniser and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
      req_r      <= 1'b0;
      data_r     <= {DATA_W{1'b0}};
      ack_meta_r <= 1'b0;
      ack_sync_r <= 1'b0;
      sent_r     <= 16'd0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      in_ready_r <= (count_nxt_s != PTR_W'(DEPTH));
      busy_r     <= (count_nxt_s != {PTR_W{1'b0}}) || (state_nxt_s != IDLE);
      ack_meta_r <= AckOut;
      ack_sync_r <= ack_meta_r;
      if (load_s) begin
        data_r <= head_s;
      end
      if (toggle_s) begin
        req_r <= ~req_r;
      end
      if (sent_inc_s) begin
        sent_r <= sent_r + 16'd1;
      end
    end
  end

`ifdef INJ_DROP_ZERO_MASK_EN
  logic [7:0] drop_r;

  // Saturating count of discarded zero-mask packets (a pop without a load)
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_r <= 8'd0;
    end else if (pop_s && !load_s && (drop_r != 8'hFF)) begin
      drop_r <= drop_r + 8'd1;
    end
  end

  assign drop_count = drop_r;
`endif

  assign in_ready   = in_ready_r;
  assign busy       = busy_r;
  assign ReqOut     = req_r;
  assign DataOut    = data_r;
  assign sent_count = sent_r;

endmodule

// File: doc/spike_packet_injector.md
# spike_packet_injector

Clocked source stage that feeds the L1 (local) input port of `switch_5x5_XY`. It accepts spike events from a neuron core's synchronous logic and buffers them in a small FIFO. Each event is serialised onto the switch's two-phase bundled-data handshake (`ReqInL1`/`DataInL1`/`AckInL1`), one packet per completed handshake. It replaces the behavioural stimulus driver with synthesizable RTL.

## Interface
Parameters:
- `MSG_W`, 10, message width (upper half = neuron id, lower half = core slot)
- `ADDR_W`, 5, destination mask width (one bit per output direction)
- `DATA_W`, `MSG_W+ADDR_W`, packet width
- `DEPTH`, 8, FIFO entries (power of two, ≥2)
- `SETUP_CYC`, 2, cycles `DataOut` is stable before `ReqOut` toggles (≥1)

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `in_valid` in 1: event offered
- `in_ready` out 1: FIFO not full; the event is accepted when `in_valid && in_ready`
- `in_msg` in `MSG_W`: message field
- `in_mask` in `ADDR_W`: destination bitmask
- `ReqOut` out 1: two-phase request to the switch's `ReqInL1`
- `DataOut` out `DATA_W`: `{msg, mask}`, with the mask in bits `[ADDR_W-1:0]`; drives `DataInL1`
- `AckOut` in 1: asynchronous ack from `AckInL1`
- `busy` out 1: FIFO non-empty or a handshake is outstanding
- `sent_count` out 16: completed handshakes

## Operation
- FIFO: circular buffer with `DEPTH` entries, read/write pointers carrying an extra wrap bit. Full when the pointers are equal except for the wrap bit; empty when they are equal. Pointers wrap modulo `DEPTH`.
- `AckOut` passes through a 2-flop synchroniser to produce `ack_s`. Only `ack_s` is used internally.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head, load `DataOut`, clear the setup counter, go to SETUP.
  - SETUP: increment the counter. When it reaches `SETUP_CYC`, toggle `ReqOut` and go to WAIT_ACK.
  - WAIT_ACK: when `ack_s == ReqOut`, increment `sent_count`. Then, if the FIFO is non-empty, pop and load the next packet and go to SETUP; otherwise go to IDLE.
- `DataOut` is held constant from the load until the next load; it never changes in SETUP or WAIT_ACK.
- Push and pop in the same cycle are both performed, so occupancy is unchanged. No push can occur while full, because `in_ready` is 0.
- `sent_count` wraps from 0xFFFF to 0.
- `busy` = FIFO non-empty, or state ≠ IDLE.
- Reset, including mid-handshake, forces:
  - `ReqOut`=0, `DataOut`=0
  - synchroniser flops = 0
  - FIFO empty, `in_ready`=1
  - state IDLE, `sent_count`=0, `busy`=0
  
  Any in-flight packet is discarded. The switch must be reset in the same window so its ack also returns to 0.

## Timing
- Event accepted at edge E0. At E1, IDLE loads `DataOut`. `ReqOut` toggles at E1+`SETUP_CYC` (E3 with defaults).
- Ack return: `AckOut` toggles asynchronously. `ack_s` matches 2 edges later, and at that edge the FSM completes the handshake.
- Back-to-back: the next `DataOut` is loaded on the completing edge. `ReqOut` toggles again `SETUP_CYC` edges later.
- Minimum packet period with defaults and zero ack delay: `SETUP_CYC` + 2 (sync) + 1 = 5 cycles.
- `in_ready` is registered from the FIFO count. It deasserts on the edge that fills the FIFO, and reasserts on the edge of the first pop after full.

## Configuration
- `INJ_DROP_ZERO_MASK_EN` defined:
  - A pop whose mask is all-zero is not sent. The FSM stays in IDLE, the FIFO advances, and the internal 8-bit `drop_count` increments (saturating at 255).
  - `drop_count` is exposed as an extra output port of width 8.
  - `busy` still counts the entry until it is popped.
- Not defined: zero-mask packets are sent like any other packet, and the `drop_count` port does not exist.

## Test plan
- Single event: `in_msg`=10'h05A, `in_mask`=5'b00100, back-ack of 10 ns. Expect `DataOut`=15'h0B44 from E1, `ReqOut` 0→1 at E3, `sent_count`=1, `busy`=0 after the ack syncs.
- Fill: push 9 events while ack is held stuck. Expect 1 event immediately popped into SETUP/WAIT_ACK, then 8 accepted into the FIFO (9 total), `in_ready`=0 after the FIFO holds 8, and `ReqOut` toggled exactly once.
- Release the ack: all 9 packets go out in order; `ReqOut` toggles 9 times; `sent_count`=9; `DataOut` is stable for ≥`SETUP_CYC` cycles before each toggle.
- Simultaneous push and pop with 3 entries: occupancy stays 3, and `in_ready` stays 1.
- Reset asserted in WAIT_ACK with `ReqOut`=1: the next cycle shows `ReqOut`=0, `DataOut`=0, FIFO empty, `sent_count`=0.
- With `INJ_DROP_ZERO_MASK_EN`: push masks {0, 5'b00001, 0}. Expect 1 handshake, `drop_count`=2, `sent_count`=1.
